div_issue_ctrl: RTL

Initiator side of the EX-stage multi-cycle divide path. Accepts DIV/DIVU from the EX stage and latches its operands. It drives the iterative divider's start/annul/sign handshake, stalls the pipeline until the divider reports ready, and commits the remainder/quotient into the architectural HI/LO registers. It also owns MTHI/MTLO writes, and handles exception flushes mid-divide, including the divider's drain time.

---
 rtl/div_issue_ctrl_if.sv | 12 +
 rtl/div_issue_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: start/annul/sign/operand/result handshake between the issue controller and the divider
interface div_issue_ctrl_if;
  logic        div_start;
  logic        div_annul;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic        div_ready;
  modport master (output div_start, div_annul, div_sign, div_a, div_b, input div_result, div_ready);
  modport slave  (input div_start, div_annul, div_sign, div_a, div_b, output div_result, div_ready);
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage initiator for the iterative divider; owns HI/LO, MTHI/MTLO and the divide stall
module div_issue_ctrl #(
  parameter int unsigned FLUSH_DRAIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_div_valid_i,
  input  logic               ex_div_signed_i,
  input  logic [31:0]        ex_rs_i,
  input  logic [31:0]        ex_rt_i,
  input  logic               ex_flush_i,
  input  logic               ex_mthi_i,
  input  logic               ex_mtlo_i,
  input  logic [31:0]        ex_mt_data_i,
  div_issue_ctrl_if.master   div,
  output logic               stall_req_o,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o
);
  localparam int unsigned CW = $clog2(FLUSH_DRAIN + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, FLUSH} state_e;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          start_q;
  logic          sign_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          issue;
  logic          commit;
  logic          mt_ok;
  assign issue          = state_q == IDLE && ex_div_valid_i && !ex_flush_i;
  assign commit         = state_q == BUSY && div.div_ready && !ex_flush_i;
  assign mt_ok          = !ex_flush_i && !stall_req_o;
  assign div.div_annul  = state_q == BUSY && ex_flush_i;
  assign div.div_start  = start_q;
  assign div.div_sign   = sign_q;
  assign div.div_a      = a_q;
  assign div.div_b      = b_q;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  // DRAIN and FLUSH hold a following DIV in EX until the divider is idle again
  always_comb
    stall_req_o = state_q == IDLE ? issue :
                  state_q == BUSY ? !(div.div_ready || ex_flush_i) : ex_div_valid_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (issue) begin
          state_q <= BUSY;
          start_q <= 1'b1;
          sign_q  <= ex_div_signed_i;
          a_q     <= ex_rs_i;
          b_q     <= ex_rt_i;
        end
        BUSY: if (ex_flush_i) begin
          state_q <= FLUSH;
          start_q <= 1'b0;
          cnt_q   <= CW'(FLUSH_DRAIN);
        end else if (div.div_ready) begin
          state_q <= DRAIN;
          start_q <= 1'b0;
        end
        DRAIN: state_q <= IDLE;
        FLUSH: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_q <= IDLE;
        end
      endcase
      if (commit) begin
        hi_q <= div.div_result[63:32];
        lo_q <= div.div_result[31:0];
      end else begin
        if (mt_ok && ex_mthi_i) hi_q <= ex_mt_data_i;
        if (mt_ok && ex_mtlo_i) lo_q <= ex_mt_data_i;
      end
    end
  end
endmodule
